// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module  : button_conditioner_if
// Brief   : Button conditioner bus: raw pins, enable, frame tick and outputs.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface button_conditioner_if #(
    parameter int NUM_BTNS = 6
);
    logic                en;
    logic                frame_pulse;
    logic [NUM_BTNS-1:0] btn_pins;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_repeat;

    modport master (
        output en,
        output frame_pulse,
        output btn_pins,
        input  btn_level,
        input  btn_press,
        input  btn_repeat
    );

    modport slave (
        input  en,
        input  frame_pulse,
        input  btn_pins,
        output btn_level,
        output btn_press,
        output btn_repeat
    );
endinterface

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module  : button_conditioner
// Brief   : Synchronise, debounce and edge-detect player buttons; generate
//           frame-paced auto-repeat pulses per channel.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int                    NUM_BTNS        = 6,
    parameter int                    DEBOUNCE_W      = 16,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]            REPEAT_DELAY    = 8'd20,
    parameter logic [7:0]            REPEAT_RATE     = 8'd4
) (
    input  wire logic                 clk,
    input  wire logic                 nRst,
    button_conditioner_if.slave       bus
);

    localparam logic [DEBOUNCE_W-1:0] c_db_last =
        DEBOUNCE_CYCLES - {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_delay = 2'd1;
    localparam logic [1:0] c_rate  = 2'd2;

    logic [NUM_BTNS-1:0] r_sync1;
    logic [NUM_BTNS-1:0] r_sync2;
    logic [NUM_BTNS-1:0] r_level_q;
    logic [NUM_BTNS-1:0] w_level;
    logic [NUM_BTNS-1:0] w_press;
    logic [NUM_BTNS-1:0] w_repeat;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level_q <= '0;
        end else begin
            r_sync1   <= bus.btn_pins;
            r_sync2   <= r_sync1;
            r_level_q <= w_level;
        end
    end

    // level_q tracks regardless of en, so enabling mid-hold never fakes a press
    assign w_press = w_level & ~r_level_q & {NUM_BTNS{bus.en}};

    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
            logic [DEBOUNCE_W-1:0] r_cnt;
            logic                  r_lvl;
            logic [1:0]            r_state;
            logic [1:0]            w_state_nxt;
            logic [7:0]            r_fcnt;
            logic [7:0]            w_fcnt_nxt;
            logic [7:0]            w_fcnt_inc;
            logic                  r_rpt;
            logic                  w_rpt_nxt;
            logic                  w_rep;

            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync2[i] != r_lvl) begin
                    if (r_cnt == c_db_last) begin
                        r_lvl <= r_sync2[i];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_level[i]  = r_lvl;
            assign w_fcnt_inc  = r_fcnt + 8'd1;

            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    r_state <= c_idle;
                    r_fcnt  <= '0;
                    r_rpt   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_fcnt  <= w_fcnt_nxt;
                    r_rpt   <= w_rpt_nxt;
                end
            end

            // Release beats press, press beats a coincident frame tick
            always_comb begin
                w_state_nxt = r_state;
                w_fcnt_nxt  = r_fcnt;
                w_rpt_nxt   = 1'b0;
                if (bus.en) begin
                    if (!r_lvl) begin
                        w_state_nxt = c_idle;
                        w_fcnt_nxt  = '0;
                    end else if (w_press[i]) begin
                        w_state_nxt = c_delay;
                        w_fcnt_nxt  = '0;
                    end else if (bus.frame_pulse) begin
                        case (r_state)
                            c_delay: begin
                                if (w_fcnt_inc == REPEAT_DELAY) begin
                                    w_rpt_nxt   = 1'b1;
                                    w_fcnt_nxt  = '0;
                                    w_state_nxt = c_rate;
                                end else begin
                                    w_fcnt_nxt  = w_fcnt_inc;
                                end
                            end
                            c_rate: begin
                                if (w_fcnt_inc == REPEAT_RATE) begin
                                    w_rpt_nxt   = 1'b1;
                                    w_fcnt_nxt  = '0;
                                end else begin
                                    w_fcnt_nxt  = w_fcnt_inc;
                                end
                            end
                            default: begin
                                w_state_nxt = r_state;
                            end
                        endcase
                    end
                end
            end

            always_comb begin
                w_rep = bus.en & (w_press[i] | r_rpt);
            end

            assign w_repeat[i] = w_rep;
        end
    endgenerate

    assign bus.btn_level  = w_level;
    assign bus.btn_press  = w_press;
    assign bus.btn_repeat = w_repeat;

endmodule

`default_nettype wire
